// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the two-client memory arbiter.
//   - Default widths for the memory beat and the CPU address.
//   - Client-id and arbiter state encodings.
//   - rr_pick(): the round-robin choice between the two clients.
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif

package mem_arbiter_pkg;

    // Client ids, also the value stored in the read-id FIFO.
    localparam logic CLIENT_IC = 1'b0;
    localparam logic CLIENT_DC = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WDATA = 1'b1
    } arb_state_e;

    // With both clients requesting, the one not granted last wins.
    function automatic logic rr_pick(input logic ic_v, input logic dc_v, input logic last);
        if (ic_v && dc_v) return ~last;
        if (dc_v)         return CLIENT_DC;
        return CLIENT_IC;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// mem_arb_id_fifo: 1-bit wide FIFO holding the client id of every read
// that has been issued to memory and not yet answered.
//   clk, reset (async, active-low)
//   push/din   : enqueue an id (ignored when full)
//   pop/dout   : dequeue the head id (ignored when empty); dout is the head
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module mem_arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is not reset; pointers and count define which entries are
    // meaningful, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between the instruction
// cache (ic) and data cache (dc) memory sides.
//   clk, reset (async, active-low)
//   ic_mem_req_* / dc_mem_req_* : client request + write-data channels
//   ic_mem_resp_* / dc_mem_resp_* : read responses routed back per client
//   mem_req_* / mem_resp_*      : the same channels toward external memory
//   resp_err                    : sticky, a response arrived with no read outstanding
// Requests are granted round-robin while IDLE. A write whose data beat does
// not accompany the request locks the grant in WDATA until the beat moves.
// Read ids are queued so responses, which memory returns in order, are
// steered to the client that issued them.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = `CPU_ADDR_BITS - 4,
    parameter int DATA_BITS = `MEM_DATA_BITS,
    parameter int ID_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ic_mem_req_valid,
    output logic                   ic_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
    input  logic                   ic_mem_req_rw,
    input  logic                   ic_mem_req_data_valid,
    output logic                   ic_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
    output logic                   ic_mem_resp_valid,
    output logic [DATA_BITS-1:0]   ic_mem_resp_data,

    input  logic                   dc_mem_req_valid,
    output logic                   dc_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic                   dc_mem_req_rw,
    input  logic                   dc_mem_req_data_valid,
    output logic                   dc_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
    output logic                   dc_mem_resp_valid,
    output logic [DATA_BITS-1:0]   dc_mem_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data,

    output logic                   resp_err
);
    arb_state_e state, state_next;
    logic       wr_client, wr_client_next;
    logic       last_grant, last_grant_next;

    logic       grant;
    logic       grant_dc;
    logic       g_valid, g_rw, g_data_valid;
    logic       req_qual, req_fire, data_fire, data_ready_g;
    logic       fifo_push, fifo_pop, fifo_dout, fifo_full, fifo_empty;

    // WDATA keeps the grant on the client whose write is still owed a beat.
    assign grant    = (state == ST_WDATA) ? wr_client
                                          : rr_pick(ic_mem_req_valid, dc_mem_req_valid, last_grant);
    assign grant_dc = (grant == CLIENT_DC);

    assign g_valid           = grant_dc ? dc_mem_req_valid      : ic_mem_req_valid;
    assign g_rw              = grant_dc ? dc_mem_req_rw         : ic_mem_req_rw;
    assign g_data_valid      = grant_dc ? dc_mem_req_data_valid : ic_mem_req_data_valid;
    assign mem_req_addr      = grant_dc ? dc_mem_req_addr       : ic_mem_req_addr;
    assign mem_req_rw        = g_rw;
    assign mem_req_data_bits = grant_dc ? dc_mem_req_data_bits  : ic_mem_req_data_bits;
    assign mem_req_data_mask = grant_dc ? dc_mem_req_data_mask  : ic_mem_req_data_mask;

    // A read needs a free id slot; the check uses the pre-pop occupancy.
    assign req_qual      = g_rw | ~fifo_full;
    assign mem_req_valid = reset & (state == ST_IDLE) & g_valid & req_qual;
    assign req_fire      = mem_req_valid & mem_req_ready;

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_req_data_valid = 1'b0;
        data_ready_g       = 1'b0;
        if (reset) begin
            case (state)
                // In IDLE the beat only counts if the write request itself is
                // taken this cycle, so memory never sees data without its request.
                ST_IDLE: begin
                    mem_req_data_valid = req_fire & g_rw & g_data_valid;
                    data_ready_g       = req_fire & g_rw & mem_req_data_ready;
                end
                ST_WDATA: begin
                    mem_req_data_valid = g_data_valid;
                    data_ready_g       = mem_req_data_ready;
                end
            endcase
        end
    end

    assign data_fire = mem_req_data_valid & mem_req_data_ready;

    assign ic_mem_req_ready      = ~grant_dc & req_fire;
    assign dc_mem_req_ready      =  grant_dc & req_fire;
    assign ic_mem_req_data_ready = ~grant_dc & data_ready_g;
    assign dc_mem_req_data_ready =  grant_dc & data_ready_g;

    assign fifo_push = req_fire & ~g_rw;
    assign fifo_pop  = reset & mem_resp_valid & ~fifo_empty;

    assign ic_mem_resp_valid = fifo_pop & (fifo_dout == CLIENT_IC);
    assign dc_mem_resp_valid = fifo_pop & (fifo_dout == CLIENT_DC);
    assign ic_mem_resp_data  = mem_resp_data;
    assign dc_mem_resp_data  = mem_resp_data;

    mem_arb_id_fifo #(
        .DEPTH (ID_DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (grant),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next      = state;
        wr_client_next  = wr_client;
        last_grant_next = last_grant;
        case (state)
            ST_IDLE: begin
                if (req_fire) begin
                    last_grant_next = grant;
                    if (g_rw && !data_fire) begin
                        state_next     = ST_WDATA;
                        wr_client_next = grant;
                    end
                end
            end
            ST_WDATA: begin
                if (data_fire) state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wr_client  <= CLIENT_IC;
            last_grant <= CLIENT_IC;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_next;
            wr_client  <= wr_client_next;
            last_grant <= last_grant_next;
            if (mem_resp_valid && fifo_empty) resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// The bench plays both caches and the external memory. A transaction-level
// model (grant history, write-lock owner, queue of outstanding read owners,
// error flag) predicts the request side each cycle; read responses are
// predicted into a scoreboard queue when issued and a separate monitor pops
// and compares them whenever the DUT presents a client response.
module tb_mem_arbiter;

    localparam int AW    = 28;
    localparam int DW    = 128;
    localparam int MW    = DW / 8;
    localparam int DEPTH = 4;

    typedef struct {
        int            client;
        logic [DW-1:0] data;
    } resp_t;

    logic          clk = 1'b0;
    logic          reset;

    // Index 0 = ic, index 1 = dc.
    logic [1:0]    req_v, req_rw, req_dv;
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_bits [2];
    logic [MW-1:0] req_mask [2];
    logic [1:0]    rdy, drdy, resp_v;
    logic [DW-1:0] ic_resp_data, dc_resp_data;

    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic [MW-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          resp_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .ID_DEPTH  (DEPTH)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ic_mem_req_valid      (req_v[0]),
        .ic_mem_req_ready      (rdy[0]),
        .ic_mem_req_addr       (req_addr[0]),
        .ic_mem_req_rw         (req_rw[0]),
        .ic_mem_req_data_valid (req_dv[0]),
        .ic_mem_req_data_ready (drdy[0]),
        .ic_mem_req_data_bits  (req_bits[0]),
        .ic_mem_req_data_mask  (req_mask[0]),
        .ic_mem_resp_valid     (resp_v[0]),
        .ic_mem_resp_data      (ic_resp_data),
        .dc_mem_req_valid      (req_v[1]),
        .dc_mem_req_ready      (rdy[1]),
        .dc_mem_req_addr       (req_addr[1]),
        .dc_mem_req_rw         (req_rw[1]),
        .dc_mem_req_data_valid (req_dv[1]),
        .dc_mem_req_data_ready (drdy[1]),
        .dc_mem_req_data_bits  (req_bits[1]),
        .dc_mem_req_data_mask  (req_mask[1]),
        .dc_mem_resp_valid     (resp_v[1]),
        .dc_mem_resp_data      (dc_resp_data),
        .mem_req_valid         (mem_req_valid),
        .mem_req_ready         (mem_req_ready),
        .mem_req_addr          (mem_req_addr),
        .mem_req_rw            (mem_req_rw),
        .mem_req_data_valid    (mem_req_data_valid),
        .mem_req_data_ready    (mem_req_data_ready),
        .mem_req_data_bits     (mem_req_data_bits),
        .mem_req_data_mask     (mem_req_data_mask),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_data         (mem_resp_data),
        .resp_err              (resp_err)
    );

    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference model state.
    bit    m_last;       // client granted most recently (0 ic, 1 dc)
    bit    m_wbusy;      // a write is waiting for its data beat
    bit    m_wowner;     // owner of that write
    int    m_ids[$];     // owners of outstanding reads, oldest first
    bit    m_err;

    resp_t exp_q[$];     // scoreboard of expected client responses

    // Values observed at the last sample point, for scenario checks.
    logic [1:0] obs_rdy, obs_drdy, obs_resp;
    logic       obs_err;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        req_v = '0; req_rw = '0; req_dv = '0;
        for (int k = 0; k < 2; k++) begin
            req_addr[k] = '0;
            req_bits[k] = '0;
            req_mask[k] = '0;
        end
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b1;
        mem_resp_valid     = 1'b0;
        mem_resp_data      = '0;
    endtask

    // Memory returns one read beat this cycle; predict who should receive it.
    task automatic drive_resp();
        resp_t e;
        mem_resp_valid = 1'b1;
        mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
        if (m_ids.size() > 0) begin
            e.client = m_ids[0];
            e.data   = mem_resp_data;
            exp_q.push_back(e);
        end
    endtask

    // Called just after a falling edge with inputs already applied: checks the
    // DUT against the model shortly before the rising edge, advances the
    // model across that edge, and returns at the next falling edge.
    task automatic tick();
        int         g;
        bit         pop;
        logic       exp_mrv, exp_mdv;
        logic [1:0] exp_rdy, exp_drdy, exp_resp;
        #4;
        g = 0; exp_mrv = 0; exp_mdv = 0; exp_rdy = '0; exp_drdy = '0; exp_resp = '0;
        if (reset) begin
            if (!m_wbusy) begin
                if (req_v == 2'b11) g = m_last ? 0 : 1;
                else if (req_v[1])  g = 1;
                else                g = 0;
                exp_mrv     = req_v[g] && (req_rw[g] || m_ids.size() < DEPTH);
                exp_rdy[g]  = exp_mrv && mem_req_ready;
                exp_drdy[g] = exp_rdy[g] && req_rw[g] && mem_req_data_ready;
                exp_mdv     = exp_rdy[g] && req_rw[g] && req_dv[g];
            end else begin
                g           = m_wowner;
                exp_drdy[g] = mem_req_data_ready;
                exp_mdv     = req_dv[g];
            end
            if (mem_resp_valid && m_ids.size() > 0) exp_resp[m_ids[0]] = 1'b1;
        end
        check("mem_req_valid", mem_req_valid, exp_mrv);
        check("req_ready", rdy, exp_rdy);
        check("req_data_ready", drdy, exp_drdy);
        check("mem_req_data_valid", mem_req_data_valid, exp_mdv);
        check("resp_valid", resp_v, exp_resp);
        check("resp_err", resp_err, m_err);
        if (exp_mrv) begin
            check("mem_req_addr", mem_req_addr, req_addr[g]);
            check("mem_req_rw", mem_req_rw, req_rw[g]);
        end
        if (exp_mdv) begin
            check("mem_req_data_bits", mem_req_data_bits, req_bits[g]);
            check("mem_req_data_mask", mem_req_data_mask, req_mask[g]);
        end
        obs_rdy = rdy; obs_drdy = drdy; obs_resp = resp_v; obs_err = resp_err;

        if (reset) begin
            pop = mem_resp_valid && m_ids.size() > 0;
            if (mem_resp_valid && m_ids.size() == 0) m_err = 1;
            if (pop) void'(m_ids.pop_front());
            if (!m_wbusy) begin
                if (exp_rdy[g]) begin
                    m_last = g[0];
                    if (!req_rw[g]) m_ids.push_back(g);
                    else if (!(exp_mdv && mem_req_data_ready)) begin
                        m_wbusy  = 1;
                        m_wowner = g[0];
                    end
                end
            end else if (req_dv[g] && mem_req_data_ready) begin
                m_wbusy = 0;
            end
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_last = 0; m_wbusy = 0; m_wowner = 0; m_err = 0;
        m_ids.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        check("scoreboard drained", exp_q.size(), 0);
        clear_inputs();
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic drain();
        req_v = '0;
        for (int n = 0; n < 2 * DEPTH && m_ids.size() > 0; n++) begin
            drive_resp();
            tick();
        end
        check("fifo drained", m_ids.size(), 0);
    endtask

    // Scoreboard monitor: compares each client response against the queue.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (resp_v != 2'b00) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got resp_valid %b expected none at %0t", resp_v, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_resp_client", resp_v, (e.client == 1) ? 2'b10 : 2'b01);
                    check("sb_resp_data", (e.client == 1) ? dc_resp_data : ic_resp_data, e.data);
                end
            end
        end
    end

    initial begin
        clear_inputs();
        reset = 1'b0;

        // Simultaneous reads after reset: dc first, then ic; responses in order.
        do_reset();
        req_v = 2'b11; req_rw = 2'b00;
        req_addr[0] = AW'(28'h00A0); req_addr[1] = AW'(28'h00B0);
        tick(); check("s1 dc granted first", obs_rdy, 2'b10);
        req_v = 2'b01;
        tick(); check("s1 ic granted next", obs_rdy, 2'b01);
        req_v = 2'b00;
        drive_resp(); tick(); check("s1 first resp to dc", obs_resp, 2'b10);
        drive_resp(); tick(); check("s1 second resp to ic", obs_resp, 2'b01);

        // dc write whose beat arrives three cycles late; ic read waits.
        req_v = 2'b11; req_rw = 2'b10; req_dv = 2'b00;
        req_addr[1] = AW'(28'h0C00); req_bits[1] = {4{32'hDEAD_BEEF}}; req_mask[1] = 16'hF00F;
        tick(); check("s2 dc write accepted", obs_rdy, 2'b10);
        req_v = 2'b01;
        for (int i = 0; i < 3; i++) begin
            req_dv[1] = (i == 2);
            tick();
            check("s2 ic blocked in wdata", obs_rdy[0], 1'b0);
        end
        check("s2 beat handshake", obs_drdy, 2'b10);
        req_dv = 2'b00;
        tick(); check("s2 ic served after beat", obs_rdy, 2'b01);
        drain();

        // Back-to-back ic reads against a 4-deep id FIFO.
        do_reset();
        req_v = 2'b01; req_rw = 2'b00;
        for (int i = 0; i < 5; i++) begin
            req_addr[0] = AW'(i);
            tick();
            check("s3 read acceptance", obs_rdy[0], (i < 4));
        end
        tick(); check("s3 fifth still stalled", obs_rdy[0], 1'b0);
        drive_resp(); tick();
        check("s3 full refuses push on pop", obs_rdy[0], 1'b0);
        check("s3 pop delivered", obs_resp, 2'b01);
        tick(); check("s3 accepted after pop", obs_rdy[0], 1'b1);
        req_v = 2'b00;
        drive_resp(); tick();
        drive_resp(); tick();
        req_v = 2'b01;
        drive_resp(); tick();
        check("s3 push with pop at count 2", obs_rdy[0], 1'b1);
        check("s3 pop with push at count 2", obs_resp, 2'b01);
        drain();

        // Response with nothing outstanding.
        drive_resp(); tick();
        check("s4 no client resp", obs_resp, 2'b00);
        tick(); check("s4 resp_err set", obs_err, 1'b1);
        tick(); check("s4 resp_err sticky", obs_err, 1'b1);
        do_reset();
        check("s4 resp_err cleared", resp_err, 1'b0);

        // Reset asserted mid-cycle while in WDATA with two reads outstanding.
        req_v = 2'b01; req_rw = 2'b00;
        tick(); tick();
        req_v = 2'b10; req_rw = 2'b10; req_dv = 2'b00;
        tick(); check("s5 write accepted", obs_rdy, 2'b10);
        req_v = 2'b11; req_dv = 2'b10; mem_resp_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("s5 async mem_req_valid", mem_req_valid, 1'b0);
        check("s5 async mem_req_data_valid", mem_req_data_valid, 1'b0);
        check("s5 async req_ready", rdy, 2'b00);
        check("s5 async data_ready", drdy, 2'b00);
        check("s5 async resp_valid", resp_v, 2'b00);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        clear_inputs();
        model_reset();
        tick();
        reset = 1'b1;
        drive_resp(); tick();
        check("s5 fifo empty after reset", obs_resp, 2'b00);
        req_v = 2'b01; req_rw = 2'b00;
        tick(); check("s5 idle after reset", obs_rdy, 2'b01);
        check("s5 resp_err from empty fifo", obs_err, 1'b1);
        drain();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                req_v[k]    = ($urandom_range(0, 99) < 60);
                req_rw[k]   = ($urandom_range(0, 99) < 30);
                req_dv[k]   = ($urandom_range(0, 99) < 60);
                req_addr[k] = AW'($urandom);
                req_bits[k] = {$urandom, $urandom, $urandom, $urandom};
                req_mask[k] = MW'($urandom);
            end
            mem_req_ready      = ($urandom_range(0, 99) < 75);
            mem_req_data_ready = ($urandom_range(0, 99) < 70);
            if (m_ids.size() > 0 && $urandom_range(0, 99) < 35) drive_resp();
            tick();
        end
        req_dv = '0;
        while (m_wbusy) begin
            req_v = '0;
            req_dv[m_wowner] = 1'b1;
            mem_req_data_ready = 1'b1;
            tick();
        end
        req_dv = '0;
        drain();
        tick();
        check("final scoreboard empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
